alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: operand and result width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: unsigned operands, also treated as two's complement for overflow.
REQ-007 The block SHALL have port f, input, 5 bits: function code.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port y, output, WIDTH bits: the result.
REQ-011 The block SHALL have ports carry, zero, ovf and illegal, output, 1 bit each: status flags.

Function
REQ-012 The function codes SHALL be: 00010 ADD, 00011 SUB, 01000 AND, 01100 OR, 00000 SHR, 10000 SHL, 00100 MUL; every other code is illegal.
REQ-013 The state machine SHALL have states IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 A handshake (in_valid and in_ready both 1) SHALL capture a, b and f into internal registers.
REQ-015 On a handshake, a single-cycle op SHALL go IDLE->DONE, with out_valid=1 on the next cycle (latency 1).
REQ-016 On a handshake, MUL SHALL go IDLE->EXEC and run WIDTH shift-add iterations, one per cycle, then enter DONE (latency WIDTH+1).
REQ-017 In DONE, y and all flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 DONE SHALL go to IDLE on the cycle out_ready=1, with out_valid returning to 0.
REQ-019 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-020 ADD SHALL produce y=(a+b) mod 2^WIDTH, carry=carry-out, and ovf=signed overflow.
REQ-021 SUB SHALL produce y=(a-b) mod 2^WIDTH, carry=1 exactly when a<b unsigned (borrow), and ovf=signed overflow.
REQ-022 AND and OR SHALL be bitwise, with carry=0 and ovf=0.
REQ-023 SHR SHALL be a logical shift of a right by 1 with zero fill, carry=a[0] and ovf=0; b is ignored.
REQ-024 SHL SHALL be a logical shift of a left by 1, carry=a[WIDTH-1] and ovf=0; b is ignored.
REQ-025 MUL SHALL produce y = low WIDTH bits of the unsigned a*b, carry = OR of the high WIDTH product bits, and ovf=0.
REQ-026 zero SHALL equal (y==0) for every operation.
REQ-027 An illegal code SHALL take the single-cycle path with y=0, illegal=1, zero=1, carry=0 and ovf=0; illegal SHALL be 0 for legal codes.

Reset
REQ-028 On rst_n=0, asynchronously and regardless of state: state=IDLE, y=0, and out_valid, carry, zero, ovf and illegal=0.
REQ-029 A reset during EXEC or DONE SHALL discard the operation, and no out_valid SHALL follow.
REQ-030 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-031 The macro ALU_SEQ_MUL_EN SHALL, when defined, compile in the MUL datapath and the EXEC state per REQ-016/025.
REQ-032 Without ALU_SEQ_MUL_EN, code 00100 SHALL be treated as illegal per REQ-027, EXEC SHALL be unreachable, and no multiplier logic SHALL be synthesised.

Verification (WIDTH=4, ALU_SEQ_MUL_EN defined unless stated)
REQ-033 SUB with a=15, b=1, out_ready=1 -> next cycle out_valid=1, y=14, carry=0, zero=0, ovf=0.
REQ-034 ADD with a=15, b=1 -> y=0, carry=1, zero=1, ovf=0; ADD with a=7, b=1 -> y=8, ovf=1, carry=0.
REQ-035 MUL with a=5, b=3 -> out_valid exactly 5 cycles after the handshake, y=15, carry=0; MUL with a=15, b=15 -> y=1, carry=1; in_ready=0 throughout.
REQ-036 SHL with a=12, out_ready held 0 for 3 cycles -> y=8, carry=1 held stable with out_valid=1; in_ready=1 on the cycle after out_ready=1.
REQ-037 Code 00001 -> y=0, illegal=1, zero=1; with ALU_SEQ_MUL_EN undefined, code 00100 -> illegal=1.
REQ-038 rst_n pulsed low 2 cycles into MUL with a=9, b=9 -> outputs 0 immediately, no out_valid, in_ready=1 after release; a following ADD with a=2, b=3 -> y=5.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand handshake in, result handshake out.
interface alu_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       f;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, a, b, f, out_ready,
    input  in_ready, out_valid, y, carry, zero, ovf, illegal
  );

  modport slave (
    input  in_valid, a, b, f, out_ready,
    output in_ready, out_valid, y, carry, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, optional shift-add multiply.
// Define ALU_SEQ_MUL_EN to compile in the multiplier and the EXEC state.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam logic [4:0] F_ADD = 5'b00010;
  localparam logic [4:0] F_SUB = 5'b00011;
  localparam logic [4:0] F_AND = 5'b01000;
  localparam logic [4:0] F_OR  = 5'b01100;
  localparam logic [4:0] F_SHR = 5'b00000;
  localparam logic [4:0] F_SHL = 5'b10000;
  localparam logic [4:0] F_MUL = 5'b00100;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [4:0]       r_f;
  logic             w_hs, w_is_mul, w_done;
  logic [WIDTH:0]   w_sum, w_dif;
  logic [WIDTH-1:0] w_y;
  logic             w_c, w_o, w_ill;

  assign w_hs   = bus.in_valid && (r_state == IDLE);
  assign w_done = (r_state == DONE);

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand, r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  assign w_is_mul = (bus.f == F_MUL);

  // One shift-add step per EXEC cycle; r_prod is final after WIDTH steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (w_hs) begin
      r_mcand  <= {{WIDTH{1'b0}}, bus.a};
      r_mplier <= bus.b;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (r_state == EXEC) begin
      r_prod   <= r_mplier[0] ? r_prod + r_mcand : r_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_is_mul = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_next = w_is_mul ? EXEC : DONE;
`ifdef ALU_SEQ_MUL_EN
      EXEC: if (r_cnt == CW'(WIDTH-1)) w_next = DONE;
`endif
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_f <= '0;
    end else if (w_hs) begin
      r_a <= bus.a;
      r_b <= bus.b;
      r_f <= bus.f;
    end
  end

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_y   = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    w_ill = 1'b0;
    case (r_f)
      F_ADD: begin
        w_y = w_sum[WIDTH-1:0];
        w_c = w_sum[WIDTH];
        w_o = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      F_SUB: begin
        w_y = w_dif[WIDTH-1:0];
        w_c = w_dif[WIDTH];
        w_o = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
      end
      F_AND: w_y = r_a & r_b;
      F_OR:  w_y = r_a | r_b;
      F_SHR: begin
        w_y = {1'b0, r_a[WIDTH-1:1]};
        w_c = r_a[0];
      end
      F_SHL: begin
        w_y = {r_a[WIDTH-2:0], 1'b0};
        w_c = r_a[WIDTH-1];
      end
`ifdef ALU_SEQ_MUL_EN
      F_MUL: begin
        w_y = r_prod[WIDTH-1:0];
        w_c = |r_prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // Outputs are forced to zero outside DONE so reset and idle look clean.
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = w_done;
  assign bus.y         = w_done ? w_y : '0;
  assign bus.carry     = w_done & w_c;
  assign bus.ovf       = w_done & w_o;
  assign bus.illegal   = w_done & w_ill;
  assign bus.zero      = w_done & (w_y == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=4; MUL vectors only when ALU_SEQ_MUL_EN is set.
module tb_alu_seq;

  localparam logic [4:0] F_ADD = 5'b00010;
  localparam logic [4:0] F_SUB = 5'b00011;
  localparam logic [4:0] F_AND = 5'b01000;
  localparam logic [4:0] F_OR  = 5'b01100;
  localparam logic [4:0] F_SHR = 5'b00000;
  localparam logic [4:0] F_SHL = 5'b10000;
  localparam logic [4:0] F_MUL = 5'b00100;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_seq_if #(.WIDTH(4)) bus ();

  alu_seq #(.WIDTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Issue one request; returns cycles from handshake to out_valid.
  task automatic run_op(input logic [4:0] fc, input logic [3:0] aa, input logic [3:0] bb,
                        input logic rdy, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = aa;
    bus.b         = bb;
    bus.f         = fc;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) chk("timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("acc_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("acc_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic expect_res(input string tag, input int lat, input int exp_lat,
                            input logic [3:0] y, input logic c, input logic z,
                            input logic o, input logic il);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_y"}, {28'd0, bus.y}, {28'd0, y});
    chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, c});
    chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, o});
    chk({tag, "_illegal"}, {31'd0, bus.illegal}, {31'd0, il});
  endtask

  initial begin
    int lat;
    int seen;
    n_tests = 0;
    n_fail  = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.f = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_y", {28'd0, bus.y}, 32'd0);
    chk("rst_flags", {28'd0, bus.carry, bus.zero, bus.ovf, bus.illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op(F_SUB, 4'd15, 4'd1, 1'b1, lat);
    expect_res("sub15_1", lat, 1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("sub_auto_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("sub_auto_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op(F_ADD, 4'd15, 4'd1, 1'b0, lat);
    expect_res("add15_1", lat, 1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    accept();
    run_op(F_ADD, 4'd7, 4'd1, 1'b0, lat);
    expect_res("add7_1", lat, 1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    accept();
    run_op(F_SUB, 4'd3, 4'd5, 1'b0, lat);
    expect_res("sub3_5", lat, 1, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();
    run_op(F_SUB, 4'd8, 4'd1, 1'b0, lat);
    expect_res("sub8_1", lat, 1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    accept();
    run_op(F_AND, 4'd12, 4'd10, 1'b0, lat);
    expect_res("and", lat, 1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    accept();
    run_op(F_AND, 4'd5, 4'd10, 1'b0, lat);
    expect_res("and_zero", lat, 1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    accept();
    run_op(F_OR, 4'd12, 4'd10, 1'b0, lat);
    expect_res("or", lat, 1, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    accept();
    run_op(F_SHR, 4'd13, 4'd15, 1'b0, lat);
    expect_res("shr", lat, 1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();

    // Hold DONE with out_ready low while a stray request is presented.
    run_op(F_SHL, 4'd12, 4'd0, 1'b0, lat);
    bus.in_valid = 1'b1;
    bus.f = F_ADD;
    bus.a = 4'd1;
    bus.b = 4'd1;
    for (int i = 0; i < 3; i++) begin
      chk("shl_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("shl_hold_y", {28'd0, bus.y}, 32'd8);
      chk("shl_hold_carry", {31'd0, bus.carry}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    accept();

    run_op(5'b00001, 4'd9, 4'd3, 1'b0, lat);
    expect_res("ill_01", lat, 1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    accept();
    run_op(5'b11111, 4'd15, 4'd15, 1'b0, lat);
    expect_res("ill_1f", lat, 1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    accept();

`ifdef ALU_SEQ_MUL_EN
    run_op(F_MUL, 4'd5, 4'd3, 1'b1, lat);
    expect_res("mul5_3", lat, 5, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    accept();
    run_op(F_MUL, 4'd15, 4'd15, 1'b0, lat);
    expect_res("mul15_15", lat, 5, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    accept();
    run_op(F_MUL, 4'd4, 4'd4, 1'b0, lat);
    expect_res("mul4_4", lat, 5, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    accept();

    // Reset two cycles into a multiply must abort it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.f = F_MUL;
    bus.a = 4'd9;
    bus.b = 4'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_y", {28'd0, bus.y}, 32'd0);
    chk("mrst_flags", {28'd0, bus.carry, bus.zero, bus.ovf, bus.illegal}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("mrst_no_valid", seen, 0);
    run_op(F_ADD, 4'd2, 4'd3, 1'b0, lat);
    expect_res("mrst_add", lat, 1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    accept();
`else
    run_op(F_MUL, 4'd5, 4'd3, 1'b0, lat);
    expect_res("mul_off", lat, 1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    accept();
`endif

    // Reset while holding a result in DONE.
    run_op(F_ADD, 4'd15, 4'd1, 1'b0, lat);
    chk("drst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("drst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drst_flags", {28'd0, bus.carry, bus.zero, bus.ovf, bus.illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("drst_no_valid", seen, 0);
    run_op(F_ADD, 4'd2, 4'd3, 1'b0, lat);
    expect_res("drst_add", lat, 1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    accept();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
